// File: rtl/window_gen.sv
// 3x3 window generator: four rotating line buffers, one being written while the other three
// are swept column by column to produce 72-bit windows for the convolution stage.
module window_gen #(
    parameter int unsigned IMG_WIDTH = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_data_valid,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
    output logic        o_intr
);

    localparam int unsigned PtrW = $clog2(IMG_WIDTH);
    localparam logic [PtrW-1:0] LastCol = PtrW'(IMG_WIDTH - 1);
    localparam logic [PtrW-1:0] LastRd  = PtrW'(IMG_WIDTH - 3);

    typedef enum logic {StIdle, StRead} state_e;

    logic [7:0]      lb_q [4][IMG_WIDTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]      wr_sel_q, wr_sel_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]      rd_sel_q, rd_sel_d;
    logic [2:0]      lines_full_q, lines_full_d;
    state_e          state_q, state_d;
    logic [71:0]     data_q, data_d;
    logic            valid_q, valid_d;
    logic            intr_q, intr_d;

    logic            wr_en, line_done, rd_active, pass_end;
    logic [71:0]     win;

    // With all four buffers holding unread lines there is nowhere to put a pixel, so it is dropped.
    assign wr_en     = i_pixel_data_valid && (lines_full_q != 3'd4);
    assign line_done = wr_en && (wr_ptr_q == LastCol);
    assign rd_active = (state_q == StRead);
    assign pass_end  = rd_active && (rd_ptr_q == LastRd);

    always_comb begin
        win = '0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                win[r*24 + k*8 +: 8] = lb_q[rd_sel_q + 2'(r)][rd_ptr_q + PtrW'(k)];
            end
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        wr_sel_d     = wr_sel_q;
        rd_ptr_d     = rd_ptr_q;
        rd_sel_d     = rd_sel_q;
        lines_full_d = lines_full_q;
        state_d      = state_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        intr_d       = 1'b0;

        if (wr_en) begin
            if (line_done) begin
                wr_ptr_d = '0;
                wr_sel_d = wr_sel_q + 2'd1;
            end else begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
        end

        case ({line_done, pass_end})
            2'b10:   lines_full_d = lines_full_q + 3'd1;
            2'b01:   lines_full_d = lines_full_q - 3'd1;
            default: lines_full_d = lines_full_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (lines_full_q >= 3'd3) begin
                    state_d  = StRead;
                    rd_ptr_d = '0;
                end
            end
            StRead: begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                if (pass_end) begin
                    state_d  = StIdle;
                    rd_sel_d = rd_sel_q + 2'd1;
                    rd_ptr_d = '0;
                end
            end
        endcase

        if (rd_active) begin
            data_d  = win;
            valid_d = 1'b1;
            intr_d  = pass_end;
        end
    end

    // Buffer contents survive reset; only the bookkeeping is cleared.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            lb_q[wr_sel_q][wr_ptr_q] <= i_pixel_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q     <= '0;
            wr_sel_q     <= '0;
            rd_ptr_q     <= '0;
            rd_sel_q     <= '0;
            lines_full_q <= '0;
            state_q      <= StIdle;
            data_q       <= '0;
            valid_q      <= 1'b0;
            intr_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_sel_q     <= wr_sel_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_sel_q     <= rd_sel_d;
            lines_full_q <= lines_full_d;
            state_q      <= state_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            intr_q       <= intr_d;
        end
    end

    assign o_pixel_data       = data_q;
    assign o_pixel_data_valid = valid_q;
    assign o_intr             = intr_q;

endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen (IMG_WIDTH=8): windows are predicted from the list of lines fed since
// reset (pass p reads lines p, p+1, p+2) and compared against every captured valid output.
module tb_window_gen;

    localparam int unsigned W    = 8;
    localparam int unsigned NWIN = W - 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vin = 1'b0;
    logic [7:0]  px  = '0;
    logic [71:0] odata;
    logic        ovalid;
    logic        ointr;

    always #5 clk = ~clk;

    window_gen #(.IMG_WIDTH(W)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_pixel_data       (px),
        .i_pixel_data_valid (vin),
        .o_pixel_data       (odata),
        .o_pixel_data_valid (ovalid),
        .o_intr             (ointr)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Output capture: every valid window with its intr flag and the edge that produced it.
    logic [71:0] cap_d[$];
    bit          cap_i[$];
    int          cap_e[$];
    int          stray_intr = 0;

    always @(negedge clk) begin
        if (ovalid === 1'b1) begin
            cap_d.push_back(odata);
            cap_i.push_back(ointr);
            cap_e.push_back(edge_cnt);
        end else if (ointr !== 1'b0) begin
            stray_intr <= stray_intr + 1;
        end
    end

    // Reference model: raw lines as fed, and the edge on which each line's last pixel was taken.
    logic [7:0] mline [16][W];
    int         line_edge [16];
    int         nlines = 0;
    int         last_px_edge = 0;

    int passed = 0;
    int total  = 0;

    function automatic logic [71:0] model_win(input int p, input int c);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                w[r*24 + k*8 +: 8] = mline[p + r][c + k];
        return w;
    endfunction

    task automatic drive_px(input logic [7:0] d);
        px = d;
        vin = 1'b1;
        last_px_edge = edge_cnt + 1;
        @(posedge clk);
        #1;
        vin = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic feed_line(input bit pattern, input int max_gap);
        logic [7:0] d;
        int ln;
        ln = nlines;
        for (int c = 0; c < W; c++) begin
            d = pattern ? {ln[3:0], c[3:0]} : 8'($urandom);
            mline[nlines][c] = d;
            drive_px(d);
            if (max_gap > 0 && c != W - 1) idle($urandom_range(0, max_gap));
        end
        line_edge[nlines] = last_px_edge;
        nlines++;
    endtask

    task automatic clear_capture();
        cap_d.delete();
        cap_i.delete();
        cap_e.delete();
        stray_intr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nlines = 0;
        clear_capture();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        do_reset();
        total++;
        if (odata !== 72'h0 || ovalid !== 1'b0 || ointr !== 1'b0)
            $display("FAIL reset_outputs: got data=%h valid=%b intr=%b want 0/0/0", odata, ovalid,
                     ointr);
        else passed++;
        idle(20);
        total++;
        if (cap_d.size() != 0 || stray_intr != 0)
            $display("FAIL reset_quiet: got %0d valid cycles, %0d intr want 0", cap_d.size(),
                     stray_intr);
        else passed++;
    endtask

    task automatic test_first_pass();
        do_reset();
        for (int l = 0; l < 3; l++) feed_line(1'b1, 0);
        idle(20);
        total++;
        if (cap_d.size() != NWIN) begin
            $display("FAIL p1_count: got %0d windows want %0d", cap_d.size(), NWIN);
        end else begin
            passed++;
            total++;
            if (cap_d[0] !== 72'h22_21_20_12_11_10_02_01_00)
                $display("FAIL p1_first: got %h want %h", cap_d[0], 72'h22_21_20_12_11_10_02_01_00);
            else passed++;
            total++;
            if (cap_d[NWIN-1] !== 72'h27_26_25_17_16_15_07_06_05)
                $display("FAIL p1_last: got %h want %h", cap_d[NWIN-1],
                         72'h27_26_25_17_16_15_07_06_05);
            else passed++;
            total++;
            if (cap_e[0] != line_edge[2] + 2)
                $display("FAIL p1_latency: got edge %0d want %0d", cap_e[0], line_edge[2] + 2);
            else passed++;
            for (int i = 0; i < NWIN; i++) begin
                total++;
                if (cap_i[i] !== (i == NWIN - 1) || cap_e[i] != cap_e[0] + i)
                    $display("FAIL p1_intr_seq[%0d]: got intr=%b edge=%0d want intr=%b edge=%0d",
                             i, cap_i[i], cap_e[i], (i == NWIN - 1), cap_e[0] + i);
                else passed++;
            end
            total++;
            if (ovalid !== 1'b0 || odata !== 72'h27_26_25_17_16_15_07_06_05)
                $display("FAIL p1_hold: got valid=%b data=%h want 0 and last window", ovalid, odata);
            else passed++;
        end
        total++;
        if (stray_intr != 0) $display("FAIL p1_stray_intr: got %0d want 0", stray_intr);
        else passed++;
    endtask

    task automatic test_second_pass();
        do_reset();
        for (int l = 0; l < 4; l++) feed_line(1'b1, 0);
        idle(20);
        total++;
        if (cap_d.size() != 2 * NWIN) begin
            $display("FAIL p2_count: got %0d windows want %0d", cap_d.size(), 2 * NWIN);
        end else begin
            passed++;
            total++;
            if (cap_d[NWIN] !== 72'h32_31_30_22_21_20_12_11_10)
                $display("FAIL p2_first: got %h want %h", cap_d[NWIN],
                         72'h32_31_30_22_21_20_12_11_10);
            else passed++;
            total++;
            if (cap_i[2*NWIN-1] !== 1'b1)
                $display("FAIL p2_intr: got %b want 1", cap_i[2*NWIN-1]);
            else passed++;
        end
    endtask

    // Full model comparison for multi-pass streams, including per-pass start latency.
    task automatic test_wrap_and_timing(input bit pattern, input int max_gap, input int nl);
        int n_exp;
        int n;
        int c;
        int p;
        bit want_i;
        logic [71:0] exp_w;
        do_reset();
        for (int l = 0; l < nl; l++) feed_line(pattern, max_gap);
        idle(25);
        n_exp = (nl - 2) * NWIN;
        total++;
        if (cap_d.size() != n_exp)
            $display("FAIL stream_count: got %0d windows want %0d", cap_d.size(), n_exp);
        else passed++;
        n = (cap_d.size() < n_exp) ? cap_d.size() : n_exp;
        for (int i = 0; i < n; i++) begin
            p = i / NWIN;
            c = i % NWIN;
            exp_w = model_win(p, c);
            want_i = (c == NWIN - 1);
            total++;
            if (cap_d[i] !== exp_w || cap_i[i] !== want_i)
                $display("FAIL stream_win[%0d]: got %h intr=%b want %h intr=%b", i, cap_d[i],
                         cap_i[i], exp_w, want_i);
            else passed++;
            if (c == 0 && max_gap == 0) begin
                total++;
                if (cap_e[i] != line_edge[p + 2] + 2)
                    $display("FAIL stream_latency[pass %0d]: got edge %0d want %0d", p, cap_e[i],
                             line_edge[p + 2] + 2);
                else passed++;
            end
        end
        total++;
        if (stray_intr != 0) $display("FAIL stream_stray_intr: got %0d want 0", stray_intr);
        else passed++;
    endtask

    task automatic test_mid_pass_reset();
        bit seen;
        do_reset();
        for (int l = 0; l < 3; l++) feed_line(1'b1, 0);
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            #1;
            if (cap_d.size() >= 3) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            $display("FAIL mid_reset_wait: got %0d windows want 3 within 40 cycles", cap_d.size());
        end else begin
            passed++;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            total++;
            if (ovalid !== 1'b0 || ointr !== 1'b0 || odata !== 72'h0)
                $display("FAIL mid_reset_drop: got valid=%b intr=%b data=%h want 0/0/0", ovalid,
                         ointr, odata);
            else passed++;
            idle(15);
            total++;
            if (cap_d.size() != 3 || stray_intr != 0 || cap_i[0] || cap_i[1] || cap_i[2])
                $display("FAIL mid_reset_abort: got %0d windows, %0d stray intr want 3, 0",
                         cap_d.size(), stray_intr);
            else passed++;
        end
        nlines = 0;
        clear_capture();
        for (int l = 0; l < 3; l++) feed_line(1'b1, 0);
        idle(20);
        total++;
        if (cap_d.size() != NWIN || cap_d[0] !== 72'h22_21_20_12_11_10_02_01_00 ||
            cap_d[NWIN-1] !== 72'h27_26_25_17_16_15_07_06_05 || cap_i[NWIN-1] !== 1'b1)
            $display("FAIL mid_reset_refeed: got %0d windows first=%h want %0d first=%h",
                     cap_d.size(), (cap_d.size() > 0) ? cap_d[0] : 72'h0, NWIN,
                     72'h22_21_20_12_11_10_02_01_00);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_first_pass();
        test_second_pass();
        test_wrap_and_timing(1'b0, 0, 8);
        test_wrap_and_timing(1'b1, 0, 5);
        test_wrap_and_timing(1'b0, 3, 6);
        test_mid_pass_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
